// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiation controller:
// sequencer states, multiplier handshake phases and the default operand width.
package mod_exp_pkg;

    localparam int DEFAULT_W = 2048;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TO_A,
        S_TO_ONE,
        S_SQR,
        S_MUL,
        S_FROM,
        S_DONE
    } state_t;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_t;

endpackage

// File: rtl/mod_exp_ctrl_mm_port.sv
// Handshake with the external Montgomery multiplier: holds operands, drives the
// one-cycle mm_rst ISSUE phase, waits for mm_finish and returns the product.
module mm_port
    import mod_exp_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         issue,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] n,
    output logic [W-1:0] mm_x,
    output logic [W-1:0] mm_y,
    output logic [W-1:0] mm_n,
    output logic         mm_rst,
    input  logic         mm_finish,
    input  logic [W-1:0] mm_result,
    output logic         op_done,
    output logic [W-1:0] op_result
);

    phase_t phase;
    logic   active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_x      <= '0;
            mm_y      <= '0;
            mm_n      <= '0;
            mm_rst    <= 1'b1;
            phase     <= PH_ISSUE;
            active    <= 1'b0;
            op_done   <= 1'b0;
            op_result <= '0;
        end else begin
            op_done <= 1'b0;
            if (issue) begin
                mm_x   <= x;
                mm_y   <= y;
                mm_n   <= n;
                mm_rst <= 1'b1;
                phase  <= PH_ISSUE;
                active <= 1'b1;
            end else if (active) begin
                // mm_finish is only trusted once the multiplier has left reset
                unique case (phase)
                    PH_ISSUE: begin
                        phase  <= PH_WAIT;
                        mm_rst <= 1'b0;
                    end
                    PH_WAIT: begin
                        if (mm_finish) begin
                            op_result <= mm_result;
                            op_done   <= 1'b1;
                            active    <= 1'b0;
                            mm_rst    <= 1'b1;
                        end
                    end
                    default: phase <= PH_ISSUE;
                endcase
            end
        end
    end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod n in the
// Montgomery domain using an external multiplier reached through mm_port.
module mod_exp_ctrl
    import mod_exp_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         sys_rst_n,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [W-1:0] exp,
    input  logic [W-1:0] n,
    input  logic [W-1:0] r2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [W-1:0] mm_x,
    output logic [W-1:0] mm_y,
    output logic [W-1:0] mm_n,
    output logic         mm_rst,
    input  logic         mm_finish,
    input  logic [W-1:0] mm_result
);

    localparam int IW = $clog2(W);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t        state;
    logic [W-1:0]  base_r, exp_r, n_r, r2_r, a_r, acc_r;
    logic [W-1:0]  op_x, op_y, op_result;
    logic [IW-1:0] idx;
    logic          go, op_done;

    always_comb begin
        op_x = '0;
        op_y = '0;
        case (state)
            S_TO_A:   begin op_x = base_r; op_y = r2_r;  end
            S_TO_ONE: begin op_x = r2_r;   op_y = ONE;   end
            S_SQR:    begin op_x = acc_r;  op_y = acc_r; end
            S_MUL:    begin op_x = acc_r;  op_y = a_r;   end
            S_FROM:   begin op_x = acc_r;  op_y = ONE;   end
            default:  begin op_x = '0;     op_y = '0;    end
        endcase
    end

    mm_port #(.W(W)) u_mm_port (
        .clk       (clk),
        .rst_n     (sys_rst_n),
        .issue     (go),
        .x         (op_x),
        .y         (op_y),
        .n         (n_r),
        .mm_x      (mm_x),
        .mm_y      (mm_y),
        .mm_n      (mm_n),
        .mm_rst    (mm_rst),
        .mm_finish (mm_finish),
        .mm_result (mm_result),
        .op_done   (op_done),
        .op_result (op_result)
    );

    // go is raised together with the state change so the next op sees updated registers
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            base_r <= '0;
            exp_r  <= '0;
            n_r    <= '0;
            r2_r   <= '0;
            a_r    <= '0;
            acc_r  <= '0;
            idx    <= '0;
            go     <= 1'b0;
        end else begin
            go   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_r <= base;
                        exp_r  <= exp;
                        n_r    <= n;
                        r2_r   <= r2;
                        idx    <= IW'(W - 1);
                        busy   <= 1'b1;
                        go     <= 1'b1;
                        state  <= S_TO_A;
                    end
                end
                S_TO_A: if (op_done) begin
                    a_r   <= op_result;
                    go    <= 1'b1;
                    state <= S_TO_ONE;
                end
                S_TO_ONE: if (op_done) begin
                    acc_r <= op_result;
                    go    <= 1'b1;
                    state <= S_SQR;
                end
                S_SQR: if (op_done) begin
                    acc_r <= op_result;
                    go    <= 1'b1;
                    if (exp_r[idx]) begin
                        state <= S_MUL;
                    end else if (idx == '0) begin
                        state <= S_FROM;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= S_SQR;
                    end
                end
                S_MUL: if (op_done) begin
                    acc_r <= op_result;
                    go    <= 1'b1;
                    if (idx == '0) begin
                        state <= S_FROM;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= S_SQR;
                    end
                end
                S_FROM: if (op_done) begin
                    result <= op_result;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with W=8 and W=16 instances, each driven by a
// behavioural Montgomery multiplier with variable latency and spurious finishes.
module tb_mod_exp_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int lat_mode = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic longint mont(input longint x, input longint y, input longint m, input int w);
        longint a = 0;
        for (int i = 0; i < w; i++) begin
            if (x[i]) a = a + y;
            if (a[0]) a = a + m;
            a = a >> 1;
        end
        if (a >= m) a = a - m;
        return a;
    endfunction

    // W=8 instance
    logic       start8 = 1'b0;
    logic [7:0] base8 = '0, exp8 = '0, n8 = '0, r28 = '0;
    logic       busy8, done8, mmrst8;
    logic [7:0] result8, mmx8, mmy8, mmn8;
    logic       mmfin8 = 1'b0;
    logic [7:0] mmres8 = '0;

    mod_exp_ctrl #(.W(8)) dut8 (
        .clk(clk), .sys_rst_n(rst_n), .start(start8),
        .base(base8), .exp(exp8), .n(n8), .r2(r28),
        .busy(busy8), .done(done8), .result(result8),
        .mm_x(mmx8), .mm_y(mmy8), .mm_n(mmn8), .mm_rst(mmrst8),
        .mm_finish(mmfin8), .mm_result(mmres8)
    );

    // W=16 instance
    logic        start16 = 1'b0;
    logic [15:0] base16 = '0, exp16 = '0, n16 = '0, r216 = '0;
    logic        busy16, done16, mmrst16;
    logic [15:0] result16, mmx16, mmy16, mmn16;
    logic        mmfin16 = 1'b0;
    logic [15:0] mmres16 = '0;

    mod_exp_ctrl #(.W(16)) dut16 (
        .clk(clk), .sys_rst_n(rst_n), .start(start16),
        .base(base16), .exp(exp16), .n(n16), .r2(r216),
        .busy(busy16), .done(done16), .result(result16),
        .mm_x(mmx16), .mm_y(mmy16), .mm_n(mmn16), .mm_rst(mmrst16),
        .mm_finish(mmfin16), .mm_result(mmres16)
    );

    int ops8 = 0, unstable8 = 0, lat8 = 0;
    logic prev8 = 1'b1;
    logic [7:0] hx8 = '0, hy8 = '0, hn8 = '0;

    always @(negedge clk) begin
        if (prev8 && !mmrst8) begin
            ops8++;
            lat8 = (lat_mode != 0) ? int'($urandom_range(1, 20)) : 1;
            hx8 = mmx8; hy8 = mmy8; hn8 = mmn8;
            mmfin8 = 1'b0;
        end else if (!mmrst8) begin
            if (mmx8 !== hx8 || mmy8 !== hy8 || mmn8 !== hn8) unstable8++;
            if (!mmfin8) begin
                if (lat8 > 1) lat8--;
                else begin
                    mmfin8 = 1'b1;
                    mmres8 = 8'(mont(longint'(hx8), longint'(hy8), longint'(hn8), 8));
                end
            end
        end else begin
            mmfin8 = ($urandom_range(0, 3) == 0);
            mmres8 = 8'($urandom);
        end
        prev8 = mmrst8;
    end

    int ops16 = 0, unstable16 = 0, lat16 = 0;
    logic prev16 = 1'b1;
    logic [15:0] hx16 = '0, hy16 = '0, hn16 = '0;

    always @(negedge clk) begin
        if (prev16 && !mmrst16) begin
            ops16++;
            lat16 = int'($urandom_range(1, 20));
            hx16 = mmx16; hy16 = mmy16; hn16 = mmn16;
            mmfin16 = 1'b0;
        end else if (!mmrst16) begin
            if (mmx16 !== hx16 || mmy16 !== hy16 || mmn16 !== hn16) unstable16++;
            if (!mmfin16) begin
                if (lat16 > 1) lat16--;
                else begin
                    mmfin16 = 1'b1;
                    mmres16 = 16'(mont(longint'(hx16), longint'(hy16), longint'(hn16), 16));
                end
            end
        end else begin
            mmfin16 = ($urandom_range(0, 3) == 0);
            mmres16 = 16'($urandom);
        end
        prev16 = mmrst16;
    end

    task automatic check_reset8(input string tag);
        check({tag, "_busy"},   64'(busy8),   64'd0);
        check({tag, "_done"},   64'(done8),   64'd0);
        check({tag, "_result"}, 64'(result8), 64'd0);
        check({tag, "_mm_x"},   64'(mmx8),    64'd0);
        check({tag, "_mm_y"},   64'(mmy8),    64'd0);
        check({tag, "_mm_n"},   64'(mmn8),    64'd0);
        check({tag, "_mm_rst"}, 64'(mmrst8),  64'd1);
    endtask

    task automatic run8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                        input logic [7:0] r, input logic [7:0] want, input int want_ops,
                        input string tag);
        int ops0, uns0;
        bit seen;
        ops0 = ops8;
        uns0 = unstable8;
        seen = 1'b0;
        base8 = b; exp8 = e; n8 = m; r28 = r;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        base8 = 8'hA5; exp8 = 8'h5A; n8 = 8'h3B; r28 = 8'h77;
        check({tag, "_busy_after_start"}, 64'(busy8), 64'd1);
        for (int i = 0; i < 5000; i++) begin
            if (done8) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_in_done"}, 64'(busy8), 64'd0);
        check({tag, "_result"}, 64'(result8), 64'(want));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done8), 64'd0);
        check({tag, "_result_held"}, 64'(result8), 64'(want));
        check({tag, "_ops"}, 64'(ops8 - ops0), 64'(want_ops));
        check({tag, "_stable"}, 64'(unstable8 - uns0), 64'd0);
    endtask

    initial begin
        int ops0, uns0;
        bit seen, reached;
        repeat (3) @(negedge clk);
        check_reset8("por");
        check("por_mm_rst16", 64'(mmrst16), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run8(8'd5, 8'd3, 8'd13, 8'd3, 8'd8, 13, "pow5_3");
        lat_mode = 1;
        run8(8'd5, 8'd3, 8'd13, 8'd3, 8'd8, 13, "pow5_3_rand");
        run8(8'd2, 8'hFF, 8'd13, 8'd3, 8'd8, 19, "pow2_ff");
        run8(8'd7, 8'd0, 8'd13, 8'd3, 8'd1, 11, "exp0");
        run8(8'd7, 8'd0, 8'd1, 8'd0, 8'd0, 11, "exp0_n1");

        // reset in the middle of a multiplication
        reached = 1'b0;
        ops0 = ops8;
        base8 = 8'd5; exp8 = 8'd3; n8 = 8'd13; r28 = 8'd3;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (ops8 - ops0 >= 4 && !mmrst8) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_reached_wait", 64'(reached), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset8("midrst_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset8("midrst_release");
        run8(8'd5, 8'd3, 8'd13, 8'd3, 8'd8, 13, "after_rst");

        // W=16 with an extra start while busy
        ops0 = ops16;
        uns0 = unstable16;
        seen = 1'b0;
        base16 = 16'd2; exp16 = 16'd10; n16 = 16'd1001; r216 = 16'd620;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        base16 = 16'd3; exp16 = 16'd5;
        check("w16_busy_after_start", 64'(busy16), 64'd1);
        repeat (40) @(negedge clk);
        check("w16_busy_at_restart", 64'(busy16), 64'd1);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done16) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("w16_done_seen", 64'(seen), 64'd1);
        check("w16_result", 64'(result16), 64'd23);
        check("w16_busy_in_done", 64'(busy16), 64'd0);
        repeat (3) @(negedge clk);
        check("w16_ops", 64'(ops16 - ops0), 64'd21);
        check("w16_stable", 64'(unstable16 - uns0), 64'd0);
        check("w16_idle_after", 64'(busy16), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
